// File: rtl/timer_peripheral.sv
// timer_peripheral: memory-mapped timer, LED and seven-segment registers,
// plus a free-running SYSTICK counter, in the window 0x40000000..0x40000017.
module timer_peripheral (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  output logic [31:0] Read_data,
  output logic        Hit,
  output logic        Irq,
  output logic [7:0]  Leds,
  output logic [11:0] Digits
);

  typedef enum logic [2:0] {
    REG_TH      = 3'd0,
    REG_TL      = 3'd1,
    REG_TCON    = 3'd2,
    REG_LED     = 3'd3,
    REG_DIGI    = 3'd4,
    REG_SYSTICK = 3'd5
  } reg_sel_e;

  // Address[31:5] of the window base 0x40000000
  localparam logic [26:0] BASE_HI = 27'h200_0000;

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [7:0]  led;
  logic [11:0] digi;
  logic [31:0] systick;

  reg_sel_e sel;
  logic     wr_en;
  logic     tl_wr;

  assign sel   = reg_sel_e'(Address[4:2]);
  assign Hit   = (Address[31:5] == BASE_HI) && (Address[4:2] <= 3'd5);
  assign wr_en = MemWrite && Hit;
  assign tl_wr = wr_en && (sel == REG_TL);

  assign Irq    = tcon[1] & tcon[2];
  assign Leds   = led;
  assign Digits = digi;

  // Combinational read mux; zero unless a load hits the window
  always_comb begin
    Read_data = '0;
    if (MemRead && Hit) begin
      case (sel)
        REG_TH:      Read_data = th;
        REG_TL:      Read_data = tl;
        REG_TCON:    Read_data = {29'd0, tcon};
        REG_LED:     Read_data = {24'd0, led};
        REG_DIGI:    Read_data = {20'd0, digi};
        REG_SYSTICK: Read_data = systick;
        default:     Read_data = '0;
      endcase
    end
  end

  // Register file, timer count/reload and SYSTICK
  // CPU writes are issued after the timer update so they take priority;
  // a TL write also suppresses the overflow side effect for that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      th      <= '0;
      tl      <= '0;
      tcon    <= '0;
      led     <= '0;
      digi    <= '0;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;

      if (tcon[0] && !tl_wr) begin
        if (tl == '1) begin
          tl <= th;
          if (tcon[1]) tcon[2] <= 1'b1;
        end else begin
          tl <= tl + 32'd1;
        end
      end

      if (wr_en) begin
        case (sel)
          REG_TH:   th   <= Write_data;
          REG_TL:   tl   <= Write_data;
          REG_TCON: tcon <= Write_data[2:0];
          REG_LED:  led  <= Write_data[7:0];
          REG_DIGI: digi <= Write_data[11:0];
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_peripheral.sv
// tb_timer_peripheral: directed scoreboard bench for timer_peripheral.
module tb_timer_peripheral;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [31:0] Read_data;
  logic        Hit;
  logic        Irq;
  logic [7:0]  Leds;
  logic [11:0] Digits;

  timer_peripheral dut (
    .clk        (clk),
    .reset      (reset),
    .Address    (Address),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Write_data (Write_data),
    .Read_data  (Read_data),
    .Hit        (Hit),
    .Irq        (Irq),
    .Leds       (Leds),
    .Digits     (Digits)
  );

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_DIGI = 32'h4000_0010;
  localparam logic [31:0] A_TICK = 32'h4000_0014;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  // Reference cycle counter for SYSTICK
  logic [31:0] model_tick;
  always @(posedge clk) model_tick <= reset ? 32'd0 : model_tick + 32'd1;

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  task automatic sb_push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_empty: observed %h required an entry", obs);
    end else begin
      tag = tag_q.pop_front();
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    sb_push(tag, exp);
    sb_check(obs);
  endtask

  task automatic rd(input logic [31:0] a, input logic en, input logic [31:0] exp_d,
                    input logic exp_h, input string tag);
    sb_push({tag, "_data"}, exp_d);
    sb_push({tag, "_hit"}, {31'd0, exp_h});
    Address = a;
    MemRead = en;
    #1;
    sb_check(Read_data);
    sb_check({31'd0, Hit});
    MemRead = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Address    = a;
    Write_data = d;
    MemWrite   = 1'b1;
    @(negedge clk);
    MemWrite   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; Address = '0; MemRead = 1'b0; MemWrite = 1'b0; Write_data = '0;
    @(negedge clk);
    rd(A_TL, 1'b1, 32'd0, 1'b1, "rd_in_reset");
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    rd(A_TH,   1'b1, 32'd0, 1'b1, "rst_th");
    rd(A_TL,   1'b1, 32'd0, 1'b1, "rst_tl");
    rd(A_TCON, 1'b1, 32'd0, 1'b1, "rst_tcon");
    rd(A_LED,  1'b1, 32'd0, 1'b1, "rst_led");
    rd(A_DIGI, 1'b1, 32'd0, 1'b1, "rst_digi");
    rd(A_TICK, 1'b1, 32'd0, 1'b1, "rst_tick");
    chk("rst_irq",    {31'd0, Irq},    32'd0);
    chk("rst_leds",   {24'd0, Leds},   32'd0);
    chk("rst_digits", {20'd0, Digits}, 32'd0);

    // SYSTICK after 10 cycles, window boundaries, read strobe gating
    repeat (10) @(negedge clk);
    rd(A_TICK,        1'b1, 32'd10, 1'b1, "tick_10");
    rd(32'h4000_0018, 1'b1, 32'd0,  1'b0, "miss_18");
    rd(32'h4000_0017, 1'b1, 32'd10, 1'b1, "hit_17");
    rd(32'h3FFF_FFFC, 1'b1, 32'd0,  1'b0, "miss_below");
    rd(A_TICK,        1'b0, 32'd0,  1'b1, "no_memread");

    // Count to overflow with interrupt enabled
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'd3);
    rd(A_TL, 1'b1, 32'hFFFF_FFFE, 1'b1, "tl_start");
    chk("irq_pre", {31'd0, Irq}, 32'd0);
    @(negedge clk);
    rd(A_TL, 1'b1, 32'hFFFF_FFFF, 1'b1, "tl_max");
    @(negedge clk);
    rd(A_TL,   1'b1, 32'hFFFF_FFFC, 1'b1, "tl_reload");
    rd(A_TCON, 1'b1, 32'd7,         1'b1, "tcon_ovf");
    chk("irq_ovf", {31'd0, Irq}, 32'd1);

    // Clear status; counting continues from reload
    wr(A_TCON, 32'd3);
    chk("irq_clr", {31'd0, Irq}, 32'd0);
    rd(A_TCON, 1'b1, 32'd3,         1'b1, "tcon_clr");
    rd(A_TL,   1'b1, 32'hFFFF_FFFD, 1'b1, "tl_cont");

    // TL write in the overflow cycle wins, no status side effect
    @(negedge clk);
    @(negedge clk);
    rd(A_TL, 1'b1, 32'hFFFF_FFFF, 1'b1, "tl_max2");
    wr(A_TL, 32'd5);
    rd(A_TL,   1'b1, 32'd5, 1'b1, "tl_wr_wins");
    rd(A_TCON, 1'b1, 32'd3, 1'b1, "tcon_no_ovf");
    chk("irq_no_ovf", {31'd0, Irq}, 32'd0);

    // TH write in the overflow cycle: reload uses old TH
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TH, 32'h0000_0100);
    rd(A_TL,   1'b1, 32'hFFFF_FFFC, 1'b1, "tl_old_th");
    rd(A_TH,   1'b1, 32'h0000_0100, 1'b1, "th_new");
    rd(A_TCON, 1'b1, 32'd7,         1'b1, "tcon_th_ovf");

    // TCON write in the overflow cycle wins for all bits
    wr(A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'd3);
    rd(A_TCON, 1'b1, 32'd3,         1'b1, "tcon_wr_wins");
    rd(A_TL,   1'b1, 32'h0000_0100, 1'b1, "tl_new_th");
    chk("irq_tcon_wins", {31'd0, Irq}, 32'd0);

    // Simultaneous read and write returns pre-write value
    Address = A_LED; Write_data = 32'h1A5; MemRead = 1'b1; MemWrite = 1'b1;
    sb_push("rdwr_old", 32'd0);
    #1;
    sb_check(Read_data);
    @(negedge clk);
    MemWrite = 1'b0;
    sb_push("rdwr_new", 32'h0000_00A5);
    #1;
    sb_check(Read_data);
    MemRead = 1'b0;
    chk("leds_a5", {24'd0, Leds}, 32'h0000_00A5);

    // Low address bits ignored; SYSTICK is read-only
    wr(32'h4000_0011, 32'h0000_0FFF);
    chk("digits_fff", {20'd0, Digits}, 32'h0000_0FFF);
    rd(A_DIGI, 1'b1, 32'h0000_0FFF, 1'b1, "digi_fff");
    wr(A_TICK, 32'd0);
    rd(A_TICK, 1'b1, model_tick, 1'b1, "tick_ro");

    // One-cycle reset mid-count clears everything
    @(negedge clk);
    reset = 1'b1;
    rd(A_TL, 1'b1, 32'h0000_0104, 1'b1, "tl_before_rst");
    @(negedge clk);
    reset = 1'b0;
    rd(A_TH,   1'b1, 32'd0, 1'b1, "rst2_th");
    rd(A_TL,   1'b1, 32'd0, 1'b1, "rst2_tl");
    rd(A_TCON, 1'b1, 32'd0, 1'b1, "rst2_tcon");
    rd(A_LED,  1'b1, 32'd0, 1'b1, "rst2_led");
    rd(A_DIGI, 1'b1, 32'd0, 1'b1, "rst2_digi");
    rd(A_TICK, 1'b1, 32'd0, 1'b1, "rst2_tick");
    chk("rst2_irq",    {31'd0, Irq},    32'd0);
    chk("rst2_leds",   {24'd0, Leds},   32'd0);
    chk("rst2_digits", {20'd0, Digits}, 32'd0);
    @(negedge clk);
    rd(A_TICK, 1'b1, 32'd1, 1'b1, "tick_restart");
    rd(A_TL,   1'b1, 32'd0, 1'b1, "tl_stopped");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/timer_peripheral.md
TIMER_PERIPHERAL -- requirements
Module: timer_peripheral

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-003 SHALL have port Address, input, 32, byte address from the CPU data path (ALU result).
REQ-004 SHALL have port MemRead, input, 1, CPU load strobe.
REQ-005 SHALL have port MemWrite, input, 1, CPU store strobe.
REQ-006 SHALL have port Write_data, input, 32, store data (CPU rt register value).
REQ-007 SHALL have port Read_data, output, 32, load data returned to the CPU write-back mux.
REQ-008 SHALL have port Hit, output, 1, address falls in the peripheral window; CPU selects Read_data over DataMemory when 1.
REQ-009 SHALL have port Irq, output, 1, timer interrupt request.
REQ-010 SHALL have port Leds, output, 8, LED register.
REQ-011 SHALL have port Digits, output, 12, seven-segment drive register.

Function
REQ-012 SHALL decode Address[31:2] only; Address[1:0] ignored.
REQ-013 SHALL map word registers: 0x40000000 TH (reload, RW), 0x40000004 TL (counter, RW), 0x40000008 TCON[2:0] (RW), 0x4000000C LED[7:0] (RW), 0x40000010 DIGI[11:0] (RW), 0x40000014 SYSTICK (RO).
REQ-014 SHALL drive Hit=1 combinationally iff Address is in 0x40000000..0x40000017.
REQ-015 SHALL drive Read_data combinationally: selected register zero-extended to 32 bits when MemRead=1 and Hit=1, else 0.
REQ-016 SHALL perform a write at the clock edge when MemWrite=1 and Hit=1, storing the low register-width bits of Write_data; writes to SYSTICK and misses ignored.
REQ-017 TCON bits: [0] timer enable, [1] interrupt enable, [2] interrupt status.
REQ-018 SHALL, when TCON[0]=1 and no CPU write to TL that cycle, update TL <= TL+1 each cycle if TL != 0xFFFFFFFF.
REQ-019 SHALL, when TCON[0]=1 and TL==0xFFFFFFFF, load TL <= TH (overflow) instead of incrementing.
REQ-020 SHALL set TCON[2] on the overflow edge iff TCON[1]=1; TCON[2] clears only by CPU write or reset.
REQ-021 SHALL drive Irq = TCON[1] & TCON[2] combinationally.
REQ-022 CPU write to TL in the same cycle as increment/overflow: written value wins; no overflow side effect that cycle.
REQ-023 CPU write to TCON in the same cycle as overflow: written value wins for all three bits.
REQ-024 CPU write to TH in an overflow cycle: TL reloads the old TH; the new TH applies to later reloads.
REQ-025 SYSTICK SHALL increment by 1 every cycle out of reset, wrapping 0xFFFFFFFF -> 0.
REQ-026 Simultaneous MemRead and MemWrite: read returns pre-write value; write takes effect at the edge.
REQ-027 Leds and Digits SHALL be driven directly from their registers.
REQ-028 Latency: reads zero cycles (combinational); writes visible one cycle after the edge.

Reset
REQ-029 While reset=1 at a clock edge: TH, TL, TCON, LED, DIGI, SYSTICK all SHALL load 0; Irq, Leds, Digits become 0.
REQ-030 Reset SHALL override any concurrent write or count; reset asserted mid-countdown discards timer state.
REQ-031 Read_data and Hit SHALL remain purely address/strobe dependent during reset.

Verification
REQ-032 Reset, then read 0x40000014 after 10 cycles -> Read_data = 10 (+/-0 with fixed sampling point); read 0x40000018 -> Read_data=0, Hit=0.
REQ-033 Write TH=0xFFFFFFFC, TL=0xFFFFFFFE, TCON=3 -> TL: 0xFFFFFFFF next, then 0xFFFFFFFC; TCON reads 7 and Irq=1 from that edge.
REQ-034 With Irq=1, write TCON=3 -> Irq=0 next cycle; counting continues from TH.
REQ-035 With TL=0xFFFFFFFF and enabled, write TL=0x5 in that cycle -> TL=5, TCON[2] unchanged.
REQ-036 Write 0x1A5 to 0x4000000C and 0xFFF to 0x40000011 -> Leds=0xA5, Digits=0xFFF; store to 0x40000014 leaves SYSTICK counting.
REQ-037 Assert reset for one cycle with TCON=3 mid-count -> all registers 0, Irq=0, SYSTICK restarts at 0.
